// File: rtl/pc_fetch_unit.sv
// Program-counter unit: holds the PC, offers it to fetch over valid/ready, handles stall,
// redirect with a flush bubble, and a saturating fetch counter. Optional feature: PC_ALIGN_CHECK_EN.
module pc_fetch_unit #(
  parameter int              XLEN         = 32,
  parameter int              INC          = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int              CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             fetch_ready,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_target,
  output logic [XLEN-1:0]  pc,
  output logic             pc_valid,
  output logic [XLEN-1:0]  pc_plus_inc,
  output logic [CNT_W-1:0] fetch_count,
  output logic             misalign_err,
  output logic [1:0]       state_dbg
);

  // Handshake: pc is offered when pc_valid is high; a fetch is accepted on any
  // edge where pc_valid && fetch_ready. While pc_valid is high and fetch_ready is
  // low, pc is held unchanged until acceptance (or a redirect/reset).
  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);
  logic err_q, err_d;
  logic misaligned;
  assign misaligned   = |(redirect_target & ALIGN_MASK);
  assign misalign_err = err_q;
`else
  assign misalign_err = 1'b0;
`endif

  assign pc_valid    = (state_q == RUN) && !stall;
  assign accept      = pc_valid && fetch_ready;
  assign pc          = pc_q;
  assign pc_plus_inc = pc_q + XLEN'(INC);
  assign fetch_count = cnt_q;
  assign state_dbg   = state_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
`ifdef PC_ALIGN_CHECK_EN
    err_d   = 1'b0;
`endif
    // A redirect wins over stall and accept, from any state.
    if (redirect_valid) begin
      state_d = FLUSH;
      pc_d    = redirect_target;
`ifdef PC_ALIGN_CHECK_EN
      if (misaligned) begin
        pc_d  = TRAP_VECTOR;
        err_d = 1'b1;
      end
`endif
    end else begin
      case (state_q)
        BOOT, FLUSH: state_d = RUN;
        RUN: begin
          if (accept) begin
            pc_d = pc_plus_inc;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus randomized traffic against a
// behavioural model of the PC / bubble / counter rules.
module tb_pc_fetch_unit;

  localparam int          XLEN    = 32;
  localparam int          INC     = 4;
  localparam int          CNT_W   = 2;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [31:0] RST_VEC = 32'h0000_0000;
  localparam logic [31:0] TRP_VEC = 32'h0000_0100;

  logic             clk;
  logic             reset;
  logic             stall;
  logic             fetch_ready;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_target;
  logic [XLEN-1:0]  pc;
  logic             pc_valid;
  logic [XLEN-1:0]  pc_plus_inc;
  logic [CNT_W-1:0] fetch_count;
  logic             misalign_err;
  logic [1:0]       state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  // model state: live = the unit is past its boot/flush bubble
  logic [31:0] m_pc;
  logic        m_live;
  int          m_cnt;
  logic        m_err;

  pc_fetch_unit #(
    .XLEN(XLEN), .INC(INC), .RESET_VECTOR(RST_VEC), .TRAP_VECTOR(TRP_VEC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .fetch_ready(fetch_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .pc(pc), .pc_valid(pc_valid), .pc_plus_inc(pc_plus_inc),
    .fetch_count(fetch_count), .misalign_err(misalign_err), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic mis;
    mis = (redirect_target % INC) != 0;
    if (reset) begin
      m_pc = RST_VEC; m_live = 1'b0; m_cnt = 0; m_err = 1'b0;
    end else if (redirect_valid) begin
      m_live = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      m_pc  = mis ? TRP_VEC : redirect_target;
      m_err = mis;
`else
      m_pc  = redirect_target;
      m_err = 1'b0;
`endif
    end else begin
      m_err = 1'b0;
      if (!m_live) m_live = 1'b1;
      else if (!stall && fetch_ready) begin
        m_pc  = m_pc + INC;
        m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      end
    end
  endtask

  task automatic check_model();
    check("pc", pc, m_pc);
    check("pc_valid", {31'b0, pc_valid}, {31'b0, m_live && !stall});
    check("pc_plus_inc", pc_plus_inc, m_pc + INC);
    check("fetch_count", {30'b0, fetch_count}, m_cnt);
    check("misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic drive(input logic rst, input logic st, input logic rdy,
                       input logic rv, input logic [31:0] tgt);
    reset = rst; stall = st; fetch_ready = rdy; redirect_valid = rv; redirect_target = tgt;
  endtask

  initial begin
    m_pc = '0; m_live = 1'b0; m_cnt = 0; m_err = 1'b0;
    drive(1, 0, 0, 0, 0);
    @(negedge clk);

    // reset and first sequential fetches
    tick();
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'b0, pc_valid}, 32'd0);
    check("rst_count", {30'b0, fetch_count}, 32'd0);
    check("rst_err", {31'b0, misalign_err}, 32'd0);
    drive(0, 0, 1, 0, 0);
    tick();
    check("boot_pc0", pc, 32'h0);
    check("boot_valid", {31'b0, pc_valid}, 32'd1);
    tick();
    check("seq_pc4", pc, 32'h4);
    tick();
    check("seq_pc8", pc, 32'h8);
    check("seq_cnt2", {30'b0, fetch_count}, 32'd2);
    check("seq_ppi", pc_plus_inc, 32'hC);

    // fetch_ready low holds pc
    drive(0, 0, 1, 1, 32'h20);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_pc", pc, 32'h20);
      check("hold_valid", {31'b0, pc_valid}, 32'd1);
      check("hold_cnt", {30'b0, fetch_count}, 32'd2);
    end
    drive(0, 0, 1, 0, 0);
    tick();
    check("hold_release", pc, 32'h24);

    // redirect during BOOT, then redirect while stalled
    drive(1, 0, 0, 0, 0);
    tick();
    drive(0, 0, 1, 1, 32'h10);
    tick();
    drive(0, 0, 1, 0, 0);
    tick();
    check("at_10", pc, 32'h10);
    drive(0, 1, 1, 1, 32'h40);
    tick();
    check("stall_redir_pc", pc, 32'h40);
    drive(0, 0, 1, 0, 0);
    #1;
    check("flush_valid", {31'b0, pc_valid}, 32'd0);
    tick();
    check("post_flush_valid", {31'b0, pc_valid}, 32'd1);
    check("no_cnt_10", {30'b0, fetch_count}, 32'd0);

    // back-to-back redirects
    drive(0, 0, 1, 1, 32'h80);
    tick();
    check("b2b_bubble1", {31'b0, pc_valid}, 32'd0);
    drive(0, 0, 1, 1, 32'h90);
    tick();
    check("b2b_pc", pc, 32'h90);
    check("b2b_bubble2", {31'b0, pc_valid}, 32'd0);
    drive(0, 0, 1, 0, 0);
    tick();
    check("b2b_resume", pc, 32'h90);
    check("b2b_valid", {31'b0, pc_valid}, 32'd1);
    tick();
    check("b2b_next", pc, 32'h94);

    // wrap and saturation, then reset mid-run
    drive(0, 0, 1, 1, 32'hFFFF_FFF8);
    tick();
    drive(0, 0, 1, 0, 0);
    tick();
    tick(); check("wrap_fffc", pc, 32'hFFFF_FFFC);
    check("wrap_ppi", pc_plus_inc, 32'h0);
    tick(); check("wrap_0", pc, 32'h0);
    tick(); check("wrap_4", pc, 32'h4);
    tick(); check("sat_cnt", {30'b0, fetch_count}, 32'd3);
    drive(1, 0, 1, 0, 0);
    tick();
    check("midrst_pc", pc, RST_VEC);
    check("midrst_valid", {31'b0, pc_valid}, 32'd0);
    check("midrst_cnt", {30'b0, fetch_count}, 32'd0);

    // misaligned redirect
    drive(0, 0, 1, 0, 0);
    tick();
    drive(0, 0, 1, 1, 32'h42);
    tick();
`ifdef PC_ALIGN_CHECK_EN
    check("mis_pc", pc, 32'h100);
    check("mis_err", {31'b0, misalign_err}, 32'd1);
`else
    check("mis_pc", pc, 32'h42);
    check("mis_err", {31'b0, misalign_err}, 32'd0);
`endif
    drive(0, 0, 1, 0, 0);
    tick();
    check("mis_err_clear", {31'b0, misalign_err}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = {$urandom_range(0, 1) ? 28'hFFFF_FFF : 28'($urandom), 4'($urandom_range(0, 15))};
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) == 0, tgt);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
